ncc_set_scheduler: RTL and testbench

NCC_SET_SCHEDULER -- requirements
Module: ncc_set_scheduler

---
 rtl/ncc_set_scheduler.sv | 167 ++++++++++++++++
 tb/tb_ncc_set_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ncc_set_scheduler.sv
// Per-frame sequencer for the NCC engine: runs template fetch, window fetch and
// result write-back for each set, counts completed sets and flags end of frame.
module ncc_set_scheduler #(
  parameter int NUM_SETS = 150,
  parameter int WB_WORDS = 3,
  parameter int DATA_W   = 32,
  parameter int RC_W     = 7,
  localparam int SET_W   = $clog2(NUM_SETS + 1),
  localparam int IDX_W   = (WB_WORDS > 1) ? $clog2(WB_WORDS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ready_2_start,
  input  logic                         abort,
  input  logic                         reuse_tmpl,
  input  logic [RC_W-1:0]              template_row,
  input  logic [RC_W-1:0]              template_col,
  input  logic                         template_done,
  input  logic [RC_W-1:0]              window_row,
  input  logic [RC_W-1:0]              window_col,
  input  logic                         window_done,
  input  logic [WB_WORDS*DATA_W-1:0]   result_in,
  input  logic                         mem_gnt,
  output logic                         activate_template,
  output logic                         activate_window,
  output logic                         req,
  output logic                         rd_wr,
  output logic                         tem_win,
  output logic [RC_W-1:0]              row,
  output logic [RC_W-1:0]              col,
  output logic [DATA_W-1:0]            write_data,
  output logic [IDX_W-1:0]             wr_index,
  output logic [SET_W-1:0]             set,
  output logic                         set_done,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TEMP = 3'd1,
    WIND = 3'd2,
    WRIT = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e                       state_q, state_d;
  logic [SET_W-1:0]             set_q, set_d;
  logic [IDX_W-1:0]             wb_idx_q, wb_idx_d;
  logic [WB_WORDS*DATA_W-1:0]   wb_q, wb_d;
  logic [DATA_W-1:0]            wb_words [WB_WORDS];

  for (genvar k = 0; k < WB_WORDS; k++) begin : g_words
    assign wb_words[k] = wb_q[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      set_q    <= '0;
      wb_idx_q <= '0;
      wb_q     <= '0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      wb_idx_q <= wb_idx_d;
      wb_q     <= wb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    wb_idx_d = wb_idx_q;
    wb_d     = wb_q;
    case (state_q)
      IDLE: begin
        set_d = '0;
        if (ready_2_start) state_d = TEMP;
      end
      TEMP: begin
        if (abort) begin
          state_d = IDLE;
          set_d   = '0;
        end else if (template_done) begin
          state_d = WIND;
        end
      end
      WIND: begin
        if (abort) begin
          state_d = IDLE;
          set_d   = '0;
        end else if (window_done) begin
          wb_d     = result_in;
          wb_idx_d = '0;
          state_d  = WRIT;
        end
      end
      WRIT: begin
        if (abort) begin
          state_d  = IDLE;
          set_d    = '0;
          wb_idx_d = '0;
        end else if (mem_gnt) begin
          if (wb_idx_q == IDX_W'(WB_WORDS - 1)) begin
            set_d = set_q + SET_W'(1);
            // Template reuse only ever skips TEMP for later sets; set 0 enters via IDLE->TEMP.
            if (set_q == SET_W'(NUM_SETS - 1)) state_d = DONE;
            else if (reuse_tmpl)               state_d = WIND;
            else                               state_d = TEMP;
          end else begin
            wb_idx_d = wb_idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        set_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        set_d   = '0;
      end
    endcase
  end

  always_comb begin
    activate_template = 1'b0;
    activate_window   = 1'b0;
    req               = 1'b0;
    rd_wr             = 1'b0;
    tem_win           = 1'b0;
    row               = '0;
    col               = '0;
    write_data        = '0;
    wr_index          = '0;
    set_done          = 1'b0;
    busy              = (state_q != IDLE);
    case (state_q)
      TEMP: begin
        activate_template = 1'b1;
        req               = 1'b1;
        row               = template_row;
        col               = template_col;
      end
      WIND: begin
        activate_window = 1'b1;
        req             = 1'b1;
        tem_win         = 1'b1;
        row             = window_row;
        col             = window_col;
      end
      WRIT: begin
        req        = 1'b1;
        rd_wr      = 1'b1;
        write_data = wb_words[wb_idx_q];
        wr_index   = wb_idx_q;
      end
      DONE:    set_done = 1'b1;
      default: ;
    endcase
  end

  assign set       = set_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ncc_set_scheduler.sv
// Directed bench for ncc_set_scheduler at default parameters (150 sets, 3 words).
module tb_ncc_set_scheduler;

  localparam int NUM_SETS = 150;
  localparam int WB_WORDS = 3;
  localparam int DATA_W   = 32;
  localparam int RC_W     = 7;
  localparam int SET_W    = $clog2(NUM_SETS + 1);
  localparam int IDX_W    = 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TEMP = 3'd1;
  localparam logic [2:0] S_WIND = 3'd2;
  localparam logic [2:0] S_WRIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic clk = 1'b0;
  logic rst_n;
  logic ready_2_start, abort, reuse_tmpl;
  logic [RC_W-1:0] template_row, template_col, window_row, window_col;
  logic template_done, window_done, mem_gnt;
  logic [WB_WORDS*DATA_W-1:0] result_in;
  logic activate_template, activate_window, req, rd_wr, tem_win;
  logic [RC_W-1:0] row, col;
  logic [DATA_W-1:0] write_data;
  logic [IDX_W-1:0] wr_index;
  logic [SET_W-1:0] set;
  logic set_done, busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  int sd_cnt   = 0;

  // clock / reset
  always #5 clk = ~clk;

  ncc_set_scheduler #(
    .NUM_SETS(NUM_SETS), .WB_WORDS(WB_WORDS), .DATA_W(DATA_W), .RC_W(RC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready_2_start(ready_2_start), .abort(abort),
    .reuse_tmpl(reuse_tmpl), .template_row(template_row), .template_col(template_col),
    .template_done(template_done), .window_row(window_row), .window_col(window_col),
    .window_done(window_done), .result_in(result_in), .mem_gnt(mem_gnt),
    .activate_template(activate_template), .activate_window(activate_window),
    .req(req), .rd_wr(rd_wr), .tem_win(tem_win), .row(row), .col(col),
    .write_data(write_data), .wr_index(wr_index), .set(set), .set_done(set_done),
    .busy(busy), .dbg_state(dbg_state)
  );

  always @(posedge clk) if (set_done) sd_cnt++;

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int temp_cnt, wr_cnt, bad_cnt;

  initial begin
    rst_n = 1'b0; ready_2_start = 1'b0; abort = 1'b0; reuse_tmpl = 1'b0;
    template_row = 7'd5; template_col = 7'd6; window_row = 7'd7; window_col = 7'd8;
    template_done = 1'b0; window_done = 1'b0; mem_gnt = 1'b0;
    result_in = 96'h1111_2222_3333;

    // reset state
    #1;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_req", req, 0);
    check("rst_set", set, 0);
    check("rst_wdata", write_data, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_hold", dbg_state, S_IDLE);

    // full frame, no reuse, grant always high
    template_done = 1'b1; window_done = 1'b1; mem_gnt = 1'b1; ready_2_start = 1'b1;
    tick();
    ready_2_start = 1'b0;
    check("f_temp_state", dbg_state, S_TEMP);
    check("f_temp_act", {activate_template, activate_window, req, rd_wr, tem_win}, 5'b10100);
    check("f_temp_addr", {row, col}, {7'd5, 7'd6});
    check("f_temp_busy", busy, 1);
    tick();
    check("f_wind_state", dbg_state, S_WIND);
    check("f_wind_act", {activate_template, activate_window, req, rd_wr, tem_win}, 5'b01101);
    check("f_wind_addr", {row, col}, {7'd7, 7'd8});
    tick();
    check("f_wr0_ctl", {req, rd_wr, wr_index}, {2'b11, 2'd0});
    check("f_wr0_data", write_data, 32'h2222_3333);
    tick();
    check("f_wr1_idx", wr_index, 1);
    check("f_wr1_data", write_data, 32'h0000_1111);
    tick();
    check("f_wr2_idx", wr_index, 2);
    check("f_wr2_data", write_data, 32'h0000_0000);
    tick();
    check("f_set1_state", dbg_state, S_TEMP);
    check("f_set1_cnt", set, 1);

    temp_cnt = 1; wr_cnt = 3; bad_cnt = 0;
    for (int s = 1; s < NUM_SETS; s++) begin
      for (int c = 0; c < 5; c++) begin
        if (activate_template) temp_cnt++;
        if (req && rd_wr) wr_cnt++;
        if (set != SET_W'(s)) bad_cnt++;
        if (c >= 2 && wr_index != IDX_W'(c - 2)) bad_cnt++;
        if (set_done) bad_cnt++;
        tick();
      end
    end
    check("f_temp_visits", temp_cnt, NUM_SETS);
    check("f_write_cycles", wr_cnt, NUM_SETS * WB_WORDS);
    check("f_seq_errors", bad_cnt, 0);
    check("f_done_state", dbg_state, S_DONE);
    check("f_done_pulse", {set_done, busy}, 2'b11);
    check("f_done_set", set, NUM_SETS);
    abort = 1'b1;  // no effect in DONE
    tick();
    abort = 1'b0;
    check("f_after_state", dbg_state, S_IDLE);
    check("f_after_flags", {set_done, busy}, 2'b00);
    check("f_after_set", set, 0);
    check("f_sd_count", sd_cnt, 1);

    // grant stall at index 1, result_in change ignored, abort in WRIT
    result_in = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    ready_2_start = 1'b1;
    tick();
    ready_2_start = 1'b0;
    tick();
    tick();
    check("s_wr0_data", write_data, 32'hEEEE_FFFF);
    tick();
    mem_gnt = 1'b0;
    result_in = 96'h0;
    for (int i = 0; i < 4; i++) begin
      check("s_stall_idx", wr_index, 1);
      check("s_stall_data", write_data, 32'hCCCC_DDDD);
      if (i < 3) tick();
    end
    mem_gnt = 1'b1;
    tick();
    check("s_wr2_idx", wr_index, 2);
    check("s_wr2_data", write_data, 32'hAAAA_BBBB);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("s_abort_state", dbg_state, S_IDLE);
    check("s_abort_set", {set, busy, req}, {SET_W'(0), 2'b00});

    // template reuse, then abort in WIND at set 5
    reuse_tmpl = 1'b1;
    result_in = 96'h1111_2222_3333;
    ready_2_start = 1'b1;
    tick();
    ready_2_start = 1'b0;
    check("r_first_temp", {dbg_state, activate_template}, {S_TEMP, 1'b1});
    tick();
    temp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (activate_template) temp_cnt++;
      tick();
    end
    check("r_no_temp", temp_cnt, 0);
    check("r_wind_state", dbg_state, S_WIND);
    check("r_wind_set", set, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    reuse_tmpl = 1'b0;
    check("r_abort_state", dbg_state, S_IDLE);
    check("r_abort_set", set, 0);
    check("r_no_set_done", sd_cnt, 1);

    // asynchronous reset mid-WRIT
    ready_2_start = 1'b1;
    tick();
    ready_2_start = 1'b0;
    tick();
    tick();
    check("a_in_writ", {req, rd_wr, busy}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    check("a_async_ctl", {req, rd_wr, busy}, 3'b000);
    check("a_async_state", dbg_state, S_IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    check("a_after_set", set, 0);
    check("a_no_set_done", sd_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
